// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load funct3 codes, writeback FSM encoding, width defaults.
package cpu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RAW_DEF  = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_ext.sv
// Load data extraction: picks byte/halfword/word out of the memory word and
// sign- or zero-extends it. Misaligned accesses use the aligned-down offset.
module load_ext
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data,
    output logic            illegal,
    output logic            misalign
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = word[{offset, 3'b000} +: 8];
    assign h = word[{offset[1], 4'b0000} +: 16];

    // Decode funct3 into extended data plus alignment / legality flags
    always_comb begin
        data     = '0;
        illegal  = 1'b0;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){b[7]}}, b};
            F3_LBU: data = {{(XLEN-8){1'b0}}, b};
            F3_LH: begin
                data     = {{(XLEN-16){h[15]}}, h};
                misalign = offset[0];
            end
            F3_LHU: begin
                data     = {{(XLEN-16){1'b0}}, h};
                misalign = offset[0];
            end
            F3_LW: begin
                data     = word;
                misalign = (offset != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: merges ALU results and load responses onto the single
// register-file write port, tracks one outstanding load and buffers one ALU
// result that collides with a load response.
module wb_unit
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RAW  = RAW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [RAW-1:0]  alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [RAW-1:0]  ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    output logic            ld_ready,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_we,
    output logic [RAW-1:0]  wb_waddr,
    output logic [XLEN-1:0] wb_wdata,
    output logic            stall,
    output logic            err_misalign,
    output logic            err_funct3,
    output logic            err_spurious
);

    wb_state_e       state;
    logic [RAW-1:0]  pend_rd;
    logic [2:0]      pend_f3;
    logic [1:0]      pend_off;
    logic            hold_valid;
    logic [RAW-1:0]  hold_rd;
    logic [XLEN-1:0] hold_data;

    logic            alu_acc, ld_acc, rsp;
    logic [2:0]      ext_f3;
    logic [1:0]      ext_off;
    logic [XLEN-1:0] ext_data;
    logic            ext_ill, ext_mis;

    // A younger ALU write to the pending load's rd must wait so it lands last
    assign alu_ready = !hold_valid &&
                       !(state == WB_WAIT_MEM && alu_rd == pend_rd && alu_rd != '0);
    assign ld_ready  = (state == WB_IDLE) && !hold_valid;
    assign stall     = (state == WB_WAIT_MEM);
    assign alu_acc   = alu_valid && alu_ready;
    assign ld_acc    = ld_valid && ld_ready;
    assign rsp       = (state == WB_WAIT_MEM) && mem_rvalid;

    // Accept and response never overlap, so one extractor serves both:
    // in IDLE it flags the incoming load, in WAIT_MEM it extracts the response.
    assign ext_f3  = (state == WB_IDLE) ? ld_funct3  : pend_f3;
    assign ext_off = (state == WB_IDLE) ? ld_addr_lo : pend_off;

    load_ext #(.XLEN(XLEN)) u_ext (
        .funct3   (ext_f3),
        .offset   (ext_off),
        .word     (mem_rdata),
        .data     (ext_data),
        .illegal  (ext_ill),
        .misalign (ext_mis)
    );

    // FSM, write-port arbitration (load > held ALU > new ALU) and sticky errors
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= WB_IDLE;
            pend_rd      <= '0;
            pend_f3      <= '0;
            pend_off     <= '0;
            hold_valid   <= 1'b0;
            hold_rd      <= '0;
            hold_data    <= '0;
            wb_we        <= 1'b0;
            wb_waddr     <= '0;
            wb_wdata     <= '0;
            err_misalign <= 1'b0;
            err_funct3   <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            wb_we <= 1'b0;
            if (rsp) begin
                wb_we    <= (pend_rd != '0);
                wb_waddr <= pend_rd;
                wb_wdata <= ext_data;
                state    <= WB_IDLE;
                if (alu_acc) begin
                    hold_valid <= 1'b1;
                    hold_rd    <= alu_rd;
                    hold_data  <= alu_data;
                end
            end else if (hold_valid) begin
                wb_we      <= (hold_rd != '0);
                wb_waddr   <= hold_rd;
                wb_wdata   <= hold_data;
                hold_valid <= 1'b0;
            end else if (alu_acc) begin
                wb_we    <= (alu_rd != '0);
                wb_waddr <= alu_rd;
                wb_wdata <= alu_data;
            end

            if (ld_acc) begin
                state        <= WB_WAIT_MEM;
                pend_rd      <= ld_rd;
                pend_f3      <= ld_funct3;
                pend_off     <= ld_addr_lo;
                err_misalign <= err_misalign | ext_mis;
                err_funct3   <= err_funct3 | ext_ill;
            end

            if (state == WB_IDLE && mem_rvalid)
                err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: reset, directed sequences, a load-extension
// vector table and a randomized run against a per-register write-order model.
module tb_wb_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [2:0]  ld_funct3 = '0;
    logic [1:0]  ld_addr_lo = '0;
    logic        ld_ready;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        stall, err_misalign, err_funct3, err_spurious;

    always #5 clk = ~clk;

    wb_unit #(.XLEN(32), .RAW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
        .ld_ready(ld_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .stall(stall),
        .err_misalign(err_misalign), .err_funct3(err_funct3), .err_spurious(err_spurious)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        alu_valid = 1'b0;
        ld_valid = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Reference load extraction from the load-type rules, plain arithmetic
    function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (off * 8)) & 32'hFF;
        h = (w >> ((off / 2) * 16)) & 32'hFFFF;
        case (f3)
            3'd0: return (b ^ 32'h80) - 32'h80;
            3'd1: return (h ^ 32'h8000) - 32'h8000;
            3'd2: return w;
            3'd4: return b;
            3'd5: return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 != 0)) || (f3 == 3'd2 && off != 0);
    endfunction

    function automatic logic ref_ill(input logic [2:0] f3);
        return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    endfunction

    // One complete load: accept, dly wait cycles, response, check the write
    task automatic run_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                            input logic [31:0] word, input int dly, input logic [31:0] exp);
        ld_valid = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = off;
        #1;
        chk("ld_ready_idle", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        chk("stall_pending", stall, 1);
        chk("ld_ready_pending", ld_ready, 0);
        for (int k = 0; k < dly; k++) begin
            tick();
            chk("stall_wait", stall, 1);
        end
        mem_rvalid = 1'b1; mem_rdata = word;
        tick();
        mem_rvalid = 1'b0;
        chk("ld_we", wb_we, (rd != 0));
        chk("ld_waddr", wb_waddr, rd);
        chk("ld_wdata", wb_wdata, exp);
        chk("stall_done", stall, 0);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] word;
        logic [31:0] exp;
        logic        mis;
        logic        ill;
    } vec_t;
    vec_t vt[14];

    // randomized-run model state
    logic [31:0] expq [32][$];
    logic        out_pending, hold_exp, exp_mis, exp_ill, alu_acc, ld_acc, quiet;
    logic [4:0]  prd;
    logic [31:0] pend_word, exp_d;
    int          rsp_cnt, left;

    initial begin
        vt[0]  = '{3'd0, 2'd3, 32'h80FF1234, 32'hFFFFFF80, 1'b0, 1'b0};
        vt[1]  = '{3'd4, 2'd3, 32'h80FF1234, 32'h00000080, 1'b0, 1'b0};
        vt[2]  = '{3'd0, 2'd0, 32'h80FF1234, 32'h00000034, 1'b0, 1'b0};
        vt[3]  = '{3'd0, 2'd2, 32'h80FF1234, 32'hFFFFFFFF, 1'b0, 1'b0};
        vt[4]  = '{3'd1, 2'd2, 32'h80FF1234, 32'hFFFF80FF, 1'b0, 1'b0};
        vt[5]  = '{3'd5, 2'd2, 32'h80FF1234, 32'h000080FF, 1'b0, 1'b0};
        vt[6]  = '{3'd1, 2'd0, 32'h80FF1234, 32'h00001234, 1'b0, 1'b0};
        vt[7]  = '{3'd1, 2'd3, 32'h80FF1234, 32'hFFFF80FF, 1'b1, 1'b0};
        vt[8]  = '{3'd2, 2'd0, 32'h80FF1234, 32'h80FF1234, 1'b0, 1'b0};
        vt[9]  = '{3'd2, 2'd2, 32'h80FF1234, 32'h80FF1234, 1'b1, 1'b0};
        vt[10] = '{3'd3, 2'd0, 32'h80FF1234, 32'h00000000, 1'b0, 1'b1};
        vt[11] = '{3'd7, 2'd0, 32'h80FF1234, 32'h00000000, 1'b0, 1'b1};
        vt[12] = '{3'd6, 2'd1, 32'h80FF1234, 32'h00000000, 1'b0, 1'b1};
        vt[13] = '{3'd5, 2'd1, 32'h80FF1234, 32'h00001234, 1'b1, 1'b0};

        // reset state
        do_reset();
        chk("rst_we", wb_we, 0);
        chk("rst_waddr", wb_waddr, 0);
        chk("rst_wdata", wb_wdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_errs", {err_misalign, err_funct3, err_spurious}, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_alu_ready", alu_ready, 1);

        // ALU stream rd=1..5
        for (int i = 1; i <= 5; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i); alu_data = i * 32'h11;
            #1;
            chk("stream_ready", alu_ready, 1);
            tick();
            chk("stream_we", wb_we, 1);
            chk("stream_waddr", wb_waddr, i);
            chk("stream_wdata", wb_wdata, i * 32'h11);
        end
        alu_valid = 1'b0;
        tick();
        chk("stream_idle_we", wb_we, 0);

        // load extension table, fresh reset per vector so flags are per-entry
        for (int i = 0; i < 14; i++) begin
            do_reset();
            run_load(5'd7, vt[i].f3, vt[i].off, vt[i].word, i % 3, vt[i].exp);
            chk("tbl_misalign", err_misalign, vt[i].mis);
            chk("tbl_funct3", err_funct3, vt[i].ill);
        end

        // collision: load response and ALU result in the same cycle
        do_reset();
        ld_valid = 1'b1; ld_rd = 5'd9; ld_funct3 = F3_LW; ld_addr_lo = 2'd0;
        tick();
        ld_valid = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA0000;
        #1;
        chk("coll_alu_ready_N", alu_ready, 1);
        tick();
        mem_rvalid = 1'b0; alu_valid = 1'b0;
        #1;
        chk("coll_N1_we", wb_we, 1);
        chk("coll_N1_waddr", wb_waddr, 9);
        chk("coll_N1_wdata", wb_wdata, 32'h12345678);
        chk("coll_N1_alu_ready", alu_ready, 0);
        chk("coll_N1_ld_ready", ld_ready, 0);
        tick();
        chk("coll_N2_we", wb_we, 1);
        chk("coll_N2_waddr", wb_waddr, 3);
        chk("coll_N2_wdata", wb_wdata, 32'hAAAA0000);
        chk("coll_N2_alu_ready", alu_ready, 1);

        // WAW block on pending rd, other rd passes
        ld_valid = 1'b1; ld_rd = 5'd4; ld_funct3 = F3_LW; ld_addr_lo = 2'd0;
        tick();
        ld_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        #1;
        chk("waw_block0", alu_ready, 0);
        tick();
        chk("waw_block1", alu_ready, 0);
        chk("waw_no_write", wb_we, 0);
        alu_rd = 5'd5; alu_data = 32'h55;
        #1;
        chk("waw_other_ready", alu_ready, 1);
        tick();
        chk("waw_other_we", wb_we, 1);
        chk("waw_other_waddr", wb_waddr, 5);
        chk("waw_other_wdata", wb_wdata, 32'h55);
        alu_rd = 5'd4; alu_data = 32'h44;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("waw_block_rsp", alu_ready, 0);
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("waw_ld_waddr", wb_waddr, 4);
        chk("waw_ld_wdata", wb_wdata, 32'hDEADBEEF);
        chk("waw_release", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        chk("waw_alu_we", wb_we, 1);
        chk("waw_alu_waddr", wb_waddr, 4);
        chk("waw_alu_wdata", wb_wdata, 32'h44);

        // x0 write suppressed
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h123;
        tick();
        alu_valid = 1'b0;
        chk("x0_we", wb_we, 0);

        // reset mid-load: same-cycle response lost, later response is spurious
        ld_valid = 1'b1; ld_rd = 5'd6; ld_funct3 = F3_LW; ld_addr_lo = 2'd0;
        tick();
        ld_valid = 1'b0;
        chk("midrst_stall", stall, 1);
        rst_n = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        rst_n = 1'b1; mem_rvalid = 1'b0;
        chk("midrst_we", wb_we, 0);
        chk("midrst_wdata", wb_wdata, 0);
        chk("midrst_stall0", stall, 0);
        chk("midrst_spur0", err_spurious, 0);
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("spur_we", wb_we, 0);
        chk("spur_flag", err_spurious, 1);
        chk("spur_stall", stall, 0);
        tick();
        chk("spur_we2", wb_we, 0);
        chk("spur_sticky", err_spurious, 1);

        // randomized run against per-register write-order model
        do_reset();
        out_pending = 0; hold_exp = 0; exp_mis = 0; exp_ill = 0;
        prd = '0; pend_word = '0; rsp_cnt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (wb_we) begin
                if (expq[wb_waddr].size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rnd_write: got write x%0d=%0h, required no write", wb_waddr, wb_wdata);
                end else begin
                    exp_d = expq[wb_waddr].pop_front();
                    chk("rnd_wdata", wb_wdata, exp_d);
                end
            end
            chk("rnd_stall", stall, out_pending);
            quiet = (cyc >= 580);
            mem_rvalid = out_pending && (rsp_cnt == 0);
            mem_rdata  = mem_rvalid ? pend_word : $urandom;
            alu_valid  = !quiet && ($urandom_range(0, 1) == 1);
            alu_rd     = 5'($urandom_range(0, 7));
            alu_data   = $urandom;
            ld_valid   = !quiet && ($urandom_range(0, 3) == 0);
            ld_rd      = 5'($urandom_range(0, 7));
            ld_funct3  = 3'($urandom_range(0, 7));
            ld_addr_lo = 2'($urandom_range(0, 3));
            #1;
            chk("rnd_ld_ready", ld_ready, !out_pending && !hold_exp);
            chk("rnd_alu_ready", alu_ready,
                !hold_exp && !(out_pending && alu_rd == prd && alu_rd != 0));
            alu_acc = alu_valid && alu_ready;
            ld_acc  = ld_valid && ld_ready;
            if (alu_acc && alu_rd != 0) expq[alu_rd].push_back(alu_data);
            hold_exp = mem_rvalid && alu_acc;
            if (mem_rvalid) out_pending = 0;
            else if (out_pending) rsp_cnt--;
            if (ld_acc) begin
                pend_word = $urandom;
                if (ld_rd != 0) expq[ld_rd].push_back(ref_ext(ld_funct3, ld_addr_lo, pend_word));
                exp_mis = exp_mis | ref_mis(ld_funct3, ld_addr_lo);
                exp_ill = exp_ill | ref_ill(ld_funct3);
                out_pending = 1;
                prd = ld_rd;
                rsp_cnt = $urandom_range(0, 3);
            end
            tick();
        end
        idle_in();
        left = 0;
        for (int r = 0; r < 32; r++) left += expq[r].size();
        chk("rnd_writes_left", left, 0);
        chk("rnd_misalign", err_misalign, exp_mis);
        chk("rnd_funct3", err_funct3, exp_ill);
        chk("rnd_spurious", err_spurious, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
